// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_unit_pkg                                           |
// | Shared fetch-stage state encodings.                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instruction_fetch_unit_pkg;

  localparam int FETCH_STATE_WIDTH = 1;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_STATE_RUN   = 1'b0,
    FETCH_STATE_DRAIN = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Small synchronous FIFO with flush; flush overrides push and pop.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_unit                                               |
// | Decoupled fetch: credit-limited requests, prefetch queue, redirect.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_Redirect_PC,
  output logic            o_Mem_Req_Valid,
  input  logic            i_Mem_Req_Ready,
  output logic [XLEN-1:0] o_Mem_Req_Addr,
  input  logic            i_Mem_Resp_Valid,
  input  logic [XLEN-1:0] i_Mem_Resp_Data,
  output logic            o_Instr_Valid,
  input  logic            i_Instr_Ready,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_Instr_PC
);

  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W = 2 * XLEN;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic               req_fire;
  logic               resp_fire;
  logic               resp_keep;
  logic               consume_fire;
  logic [CNT_W:0]     credit_used;
  logic [CNT_W-1:0]   queue_count;
  logic [CNT_W-1:0]   pend_count;
  logic               queue_full, queue_empty;
  logic               pend_full, pend_empty;
  logic [ENTRY_W-1:0] queue_head;
  logic [ENTRY_W-1:0] queue_in;
  logic [XLEN-1:0]    pend_head;
  logic               unused_status;

  // Credits cover queued entries plus requests in flight, so a response always finds room.
  assign credit_used     = {1'b0, queue_count} + {1'b0, outstanding_q};
  assign o_Mem_Req_Valid = (state_q == FETCH_STATE_RUN) &&
                           (credit_used < (CNT_W + 1)'(QUEUE_DEPTH));
  assign o_Mem_Req_Addr  = fetch_pc_q;

  assign req_fire     = o_Mem_Req_Valid && i_Mem_Req_Ready;
  assign resp_fire    = i_Mem_Resp_Valid && (outstanding_q != '0);
  assign resp_keep    = resp_fire && (state_q == FETCH_STATE_RUN) && !i_Redirect;
  assign consume_fire = o_Instr_Valid && i_Instr_Ready;
  assign queue_in     = {pend_head, i_Mem_Resp_Data};

  assign o_Instr_Valid = !queue_empty;
  assign o_Instr       = queue_empty ? '0 : queue_head[XLEN-1:0];
  assign o_Instr_PC    = queue_empty ? '0 : queue_head[ENTRY_W-1:XLEN];

  assign unused_status = ^{queue_full, pend_full, pend_empty, pend_count};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_count_d  = drop_count_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if ((state_q == FETCH_STATE_DRAIN) && resp_fire) begin
      drop_count_d = drop_count_q - 1'b1;
    end
    // Everything still in flight after this cycle, including a same-cycle request, is stale.
    if (i_Redirect) begin
      fetch_pc_d   = {i_Redirect_PC[XLEN-1:2], 2'b00};
      drop_count_d = outstanding_d;
      state_d      = (outstanding_d != '0) ? FETCH_STATE_DRAIN : FETCH_STATE_RUN;
    end else if ((state_q == FETCH_STATE_DRAIN) && (drop_count_d == '0)) begin
      state_d = FETCH_STATE_RUN;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= FETCH_STATE_RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
    end
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_instr_queue (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_flush (i_Redirect),
    .i_push  (resp_keep),
    .i_data  (queue_in),
    .i_pop   (consume_fire),
    .o_data  (queue_head),
    .o_full  (queue_full),
    .o_empty (queue_empty),
    .o_count (queue_count)
  );

  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (QUEUE_DEPTH)
  ) u_pend_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_flush (i_Redirect),
    .i_push  (req_fire),
    .i_data  (fetch_pc_q),
    .i_pop   (resp_fire && (state_q == FETCH_STATE_RUN)),
    .o_data  (pend_head),
    .o_full  (pend_full),
    .o_empty (pend_empty),
    .o_count (pend_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch_unit                                            |
// | Directed bench with an in-order variable-latency memory model.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks = 0;
  int n_bad    = 0;
  int mem_lat  = 1;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [63:0] del_log[$];

  instruction_fetch_unit #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Redirect       (redirect),
    .i_Redirect_PC    (redirect_pc),
    .o_Mem_Req_Valid  (mem_req_valid),
    .i_Mem_Req_Ready  (mem_req_ready),
    .o_Mem_Req_Addr   (mem_req_addr),
    .i_Mem_Resp_Valid (mem_resp_valid),
    .i_Mem_Resp_Data  (mem_resp_data),
    .o_Instr_Valid    (instr_valid),
    .i_Instr_Ready    (instr_ready),
    .o_Instr          (instr),
    .o_Instr_PC       (instr_pc)
  );

  always #5 clk = ~clk;

  // Memory returns the bitwise inverse of the address, mem_lat cycles after acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (mem_resp_valid) mq.pop_front();
      if (mem_req_valid && mem_req_ready) mq.push_back(mreq_t'{mem_req_addr, cyc + mem_lat});
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        mem_resp_valid <= 1'b1;
        mem_resp_data  <= ~mq[0].addr;
      end else begin
        mem_resp_valid <= 1'b0;
        mem_resp_data  <= '0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
      if (instr_valid && instr_ready) del_log.push_back({instr_pc, instr});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_log.delete();
    del_log.delete();
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    req_log.delete();
    del_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    // Reset values and sequential fetch with a 1-cycle memory
    mem_lat     = 1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_instr", 64'(instr), 64'h0);
    check("rst_pc", 64'(instr_pc), 64'h0);
    do_reset();
    #1;
    check("rel_req_valid", 64'(mem_req_valid), 64'h1);
    check("rel_req_addr", 64'(mem_req_addr), 64'h0);
    @(negedge clk);
    check("lat_valid_e0", 64'(instr_valid), 64'h0);
    @(negedge clk);
    check("lat_valid_e1", 64'(instr_valid), 64'h1);
    check("lat_pc_e1", 64'(instr_pc), 64'h0);
    repeat (16) @(negedge clk);
    check("seq_req0", 64'(req_log[0]), 64'h0);
    check("seq_req1", 64'(req_log[1]), 64'h4);
    check("seq_req2", 64'(req_log[2]), 64'h8);
    check("seq_n_del", 64'(del_log.size() >= 3), 64'h1);
    check("seq_del0", del_log[0], 64'h0000_0000_FFFF_FFFF);
    check("seq_del1", del_log[1], 64'h0000_0004_FFFF_FFFB);
    check("seq_del2", del_log[2], 64'h0000_0008_FFFF_FFF7);

    // Back-pressure: credits stop requests at QUEUE_DEPTH
    instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check("bp_n_req", 64'(req_log.size()), 64'd2);
    check("bp_req_valid", 64'(mem_req_valid), 64'h0);
    check("bp_pc", 64'(instr_pc), 64'h0);
    check("bp_instr", 64'(instr), 64'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    check("bp_pc_stable", 64'(instr_pc), 64'h0);
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_del0_pc", 64'(del_log[0][63:32]), 64'h0);
    check("bp_del1_pc", 64'(del_log[1][63:32]), 64'h4);

    // Redirect with two stale responses in flight, 3-cycle memory
    mem_lat     = 3;
    instr_ready = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    instr_ready = 1'b1;
    pulse_redirect(32'h0000_0100);
    @(negedge clk);
    check("rd3_instr_valid", 64'(instr_valid), 64'h0);
    check("rd3_drain_e2", 64'(mem_req_valid), 64'h0);
    @(negedge clk);
    check("rd3_drain_e3", 64'(mem_req_valid), 64'h0);
    @(negedge clk);
    check("rd3_resume_valid", 64'(mem_req_valid), 64'h1);
    check("rd3_resume_addr", 64'(mem_req_addr), 64'h100);
    repeat (12) @(negedge clk);
    check("rd3_req0", 64'(req_log[0]), 64'h100);
    check("rd3_del0", del_log[0], 64'h0000_0100_FFFF_FEFF);
    check("rd3_del1_pc", 64'(del_log[1][63:32]), 64'h104);

    // Redirect in the same cycle as the request for 0x8
    mem_lat     = 3;
    instr_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req_valid && mem_req_addr == 32'h8) found = 1'b1;
      else @(negedge clk);
    end
    check("rdq_saw_req8", 64'(found), 64'h1);
    pulse_redirect(32'h0000_0040);
    @(negedge clk);
    check("rdq_instr_valid", 64'(instr_valid), 64'h0);
    check("rdq_drain_r0", 64'(mem_req_valid), 64'h0);
    repeat (2) @(negedge clk);
    check("rdq_drain_r2", 64'(mem_req_valid), 64'h0);
    @(negedge clk);
    check("rdq_resume_valid", 64'(mem_req_valid), 64'h1);
    check("rdq_resume_addr", 64'(mem_req_addr), 64'h40);
    repeat (10) @(negedge clk);
    check("rdq_del0", del_log[0], 64'h0000_0040_FFFF_FFBF);

    // Unaligned target and address wrap
    mem_lat     = 1;
    instr_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    pulse_redirect(32'h0000_0203);
    repeat (8) @(negedge clk);
    check("al_req0", 64'(req_log[0]), 64'h200);
    check("al_del0", del_log[0], 64'h0000_0200_FFFF_FDFF);
    pulse_redirect(32'hFFFF_FFFC);
    repeat (10) @(negedge clk);
    check("wr_req0", 64'(req_log[0]), 64'hFFFF_FFFC);
    check("wr_n_req", 64'(req_log.size() >= 2), 64'h1);
    check("wr_req1", 64'(req_log[1]), 64'h0);
    check("wr_del0", del_log[0], 64'hFFFF_FFFC_0000_0003);
    check("wr_del1", del_log[1], 64'h0000_0000_FFFF_FFFF);

    // Asynchronous reset with responses in flight
    mem_lat     = 3;
    instr_ready = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    check("ar_pre_valid", 64'(instr_valid), 64'h1);
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(instr_valid), 64'h0);
    check("ar_instr", 64'(instr), 64'h0);
    check("ar_pc", 64'(instr_pc), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    req_log.delete();
    del_log.delete();
    #1;
    check("ar_rel_valid", 64'(mem_req_valid), 64'h1);
    check("ar_rel_addr", 64'(mem_req_addr), 64'h0);
    instr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ar_del0", del_log[0], 64'h0000_0000_FFFF_FFFF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
